keypad_entry_buffer: RTL and testbench

Sits directly downstream of the keypad scanner. It consumes the scanner's 4-bit key code and one-cycle key pulse, and assembles decimal digits into a multi-digit BCD entry buffer. The buffer supports clear, backspace and enter command keys. On enter, the committed value goes to the downstream consumer over a valid/ready handshake. An idle timeout discards a partial entry.

---
 rtl/keypad_entry_buffer.sv | 120 ++++++++++++
 tb/tb_keypad_entry_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: assembles scanner key presses into a BCD entry buffer
// and hands the committed value downstream over valid/ready.
module keypad_entry_buffer #(
    parameter int         NUM_DIGITS     = 4,
    parameter logic [3:0] CLEAR_KEY      = 4'hA,
    parameter logic [3:0] BACK_KEY       = 4'hB,
    parameter logic [3:0] ENTER_KEY      = 4'hE,
    parameter int         TIMEOUT_CYCLES = 500000000,
    parameter int         TIMER_BITS     = 29,
    localparam int        W              = 4 * NUM_DIGITS,
    localparam int        CW             = $clog2(NUM_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    key,
    input  logic          key_detected,
    output logic [W-1:0]  entry_digits,
    output logic [CW-1:0] digit_count,
    output logic [W-1:0]  value_bcd,
    output logic          value_valid,
    input  logic          value_ready,
    output logic          key_rejected,
    output logic          timeout
);
    typedef enum logic [1:0] {EMPTY, ENTRY, PENDING} state_t;

    localparam logic [TIMER_BITS-1:0] TERM = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [W-1:0]          buf_q, buf_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W-1:0]          value_q, value_d;
    logic                  rej_q, rej_d;
    logic                  to_q, to_d;
    logic [TIMER_BITS-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            buf_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            rej_q   <= 1'b0;
            to_q    <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            rej_q   <= rej_d;
            to_q    <= to_d;
            tmr_q   <= tmr_d;
        end
    end

    // The idle timer defaults to 0 so any key or state change restarts it.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        rej_d   = 1'b0;
        to_d    = 1'b0;
        tmr_d   = '0;
        if (state_q == PENDING) begin
            rej_d = key_detected;
            if (value_ready) state_d = EMPTY;
        end else if (key_detected) begin
            if (key == CLEAR_KEY) begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = EMPTY;
            end else if (key == BACK_KEY) begin
                if (cnt_q == '0) begin
                    rej_d = 1'b1;
                end else begin
                    buf_d   = buf_q >> 4;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == CW'(1)) ? EMPTY : ENTRY;
                end
            end else if (key == ENTER_KEY) begin
                if (cnt_q == '0) begin
                    rej_d = 1'b1;
                end else begin
                    value_d = buf_q;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = PENDING;
                end
            end else if (key <= 4'd9) begin
                if (cnt_q == CW'(NUM_DIGITS)) begin
                    rej_d = 1'b1;
                end else begin
                    buf_d   = {buf_q[W-5:0], key};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ENTRY;
                end
            end else begin
                rej_d = 1'b1;
            end
        end else if (state_q == ENTRY) begin
            if (tmr_q == TERM) begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = EMPTY;
                to_d    = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
    end

    assign entry_digits = buf_q;
    assign digit_count  = cnt_q;
    assign value_bcd    = value_q;
    assign value_valid  = (state_q == PENDING);
    assign key_rejected = rej_q;
    assign timeout      = to_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer: directed key sequences with a scoreboard of
// committed values checked at each valid/ready transfer.
module tb_keypad_entry_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key = 4'h0;
    logic        key_detected = 1'b0;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        value_ready = 1'b1;
    logic        key_rejected;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    logic [15:0] exp_q[$];

    keypad_entry_buffer #(.TIMEOUT_CYCLES(20), .TIMER_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_detected(key_detected),
        .entry_digits(entry_digits), .digit_count(digit_count),
        .value_bcd(value_bcd), .value_valid(value_valid), .value_ready(value_ready),
        .key_rejected(key_rejected), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; this samples a stable handshake.
    always @(negedge clk) begin
        if (rst_n && value_valid && value_ready) begin
            xfers++;
            chk("xfer_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("xfer_value", value_bcd, exp_q.pop_front());
        end
    end

    task automatic press(input logic [3:0] k);
        @(posedge clk); #1;
        key = k;
        key_detected = 1'b1;
        @(posedge clk); #1;
        key_detected = 1'b0;
        @(negedge clk);
    endtask

    task automatic buf_is(input string tag, input logic [15:0] d, input logic [2:0] c);
        chk({tag, "_digits"}, entry_digits, d);
        chk({tag, "_count"}, digit_count, c);
    endtask

    initial begin
        #12;
        chk("rst_digits", entry_digits, 0);
        chk("rst_valid", value_valid, 0);
        chk("rst_bcd", value_bcd, 0);
        chk("rst_rej", key_rejected, 0);
        chk("rst_to", timeout, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        press(4'h1); press(4'h2); press(4'h3);
        buf_is("t1", 16'h0123, 3);
        exp_q.push_back(16'h0123);
        press(4'hE);
        chk("t1_valid", value_valid, 1);
        chk("t1_bcd", value_bcd, 16'h0123);
        buf_is("t1_clr", 16'h0000, 0);
        @(negedge clk);
        chk("t1_valid_drop", value_valid, 0);
        chk("t1_xfers", xfers, 1);
        chk("t1_bcd_hold", value_bcd, 16'h0123);

        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        buf_is("t2", 16'h9876, 4);
        chk("t2_norej", key_rejected, 0);
        press(4'h5);
        chk("t2_rej", key_rejected, 1);
        buf_is("t2_full", 16'h9876, 4);
        @(negedge clk);
        chk("t2_rej_pulse", key_rejected, 0);
        press(4'hC);
        chk("t2_rej_c", key_rejected, 1);
        press(4'hA);
        buf_is("t2_clr", 16'h0000, 0);

        press(4'h4); press(4'h5);
        buf_is("t3_a", 16'h0045, 2);
        press(4'hB);
        buf_is("t3_b", 16'h0004, 1);
        press(4'h7);
        buf_is("t3_c", 16'h0047, 2);
        press(4'hA);
        buf_is("t3_d", 16'h0000, 0);
        chk("t3_clr_norej", key_rejected, 0);
        press(4'hB);
        chk("t3_back_rej", key_rejected, 1);
        press(4'hE);
        chk("t3_enter_rej", key_rejected, 1);
        chk("t3_enter_novalid", value_valid, 0);

        value_ready = 1'b0;
        press(4'h1); press(4'h2);
        exp_q.push_back(16'h0012);
        press(4'hE);
        chk("t4_valid", value_valid, 1);
        press(4'h3);
        chk("t4_rej", key_rejected, 1);
        chk("t4_hold_valid", value_valid, 1);
        chk("t4_hold_bcd", value_bcd, 16'h0012);
        buf_is("t4_buf", 16'h0000, 0);
        @(posedge clk); #1 value_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_valid_drop", value_valid, 0);
        chk("t4_xfers", xfers, 2);

        press(4'h5);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk($sformatf("t5_to_%0d", i), timeout, i == 20);
        end
        buf_is("t5_clr", 16'h0000, 0);
        @(negedge clk);
        chk("t5_to_pulse", timeout, 0);

        press(4'h5);
        repeat (19) @(posedge clk);
        #1 key = 4'h6; key_detected = 1'b1;
        @(posedge clk); #1 key_detected = 1'b0;
        @(negedge clk);
        chk("t6_noto", timeout, 0);
        buf_is("t6", 16'h0056, 2);
        repeat (5) @(negedge clk);
        chk("t6_noto_late", timeout, 0);
        press(4'hA);

        value_ready = 1'b0;
        press(4'h7);
        press(4'hE);
        chk("t7_valid", value_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", value_valid, 0);
        chk("t7_rst_bcd", value_bcd, 0);
        buf_is("t7_rst", 16'h0000, 0);
        @(posedge clk); #1 rst_n = 1'b1; value_ready = 1'b1;
        press(4'h1); press(4'h2);
        #2 rst_n = 1'b0;
        #1;
        buf_is("t8_rst", 16'h0000, 0);
        chk("t8_rst_rej", key_rejected, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        press(4'h8);
        buf_is("t8_after", 16'h0008, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("total_xfers", xfers, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
